// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit owning the HI/LO pair; one radix-2 step per cycle.
// Define MULDIV_DIV_EN to build the restoring divider; without it div/divu complete as no-ops.
module muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         op_valid,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         op_ready,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DZ} state_t;

    state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [N-1:0]   acc_q, acc_d, quo_q, quo_d, bm_q, bm_d;
    logic           neg_q, neg_d, done_q, done_d, dbz_q, dbz_d;
`ifdef MULDIV_DIV_EN
    logic           is_div_q, is_div_d, sa_q, sa_d;
    logic           b_zero;
    logic [N:0]     shifted, diff;
`endif

    logic           is_mul, is_div, is_mt, is_signed, accept;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     sum;
    logic [2*N-1:0] prod;

    assign is_mul    = (op == 3'd0) || (op == 3'd1);
    assign is_div    = (op == 3'd2) || (op == 3'd3);
    assign is_mt     = (op == 3'd4) || (op == 3'd5);
    assign is_signed = ~op[0];
    assign accept    = op_valid && op_ready && (is_mul || is_div || is_mt);
    assign a_mag     = (is_signed && a[N-1]) ? -a : a;
    assign b_mag     = (is_signed && b[N-1]) ? -b : b;
`ifdef MULDIV_DIV_EN
    assign b_zero    = (b == '0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            bm_q     <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            bm_q     <= bm_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && (is_mul || is_div)) begin
`ifdef MULDIV_DIV_EN
                    state_d = (is_div && b_zero) ? DZ : RUN;
`else
                    state_d = is_div ? DZ : RUN;
`endif
                end
            end
            RUN:     if (cnt_q == '0) state_d = FIX;
            FIX, DZ: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    // Datapath: acc holds the running high half (product) or partial remainder (divide).
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        acc_d  = acc_q;
        quo_d  = quo_q;
        bm_d   = bm_q;
        neg_d  = neg_q;
        dbz_d  = dbz_q;
        done_d = (state_q == FIX) || (state_q == DZ);
        sum    = {1'b0, acc_q} + (quo_q[0] ? {1'b0, bm_q} : '0);
        prod   = {acc_q, quo_q};
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        sa_d     = sa_q;
        shifted  = {acc_q, quo_q[N-1]};
        diff     = shifted - {1'b0, bm_q};
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dbz_d = 1'b0;
                    if (op == 3'd4) hi_d = a;
                    if (op == 3'd5) lo_d = a;
                    if (is_mul || is_div) begin
                        acc_d = '0;
                        quo_d = a_mag;
                        bm_d  = b_mag;
                        neg_d = is_signed && (a[N-1] ^ b[N-1]);
                        cnt_d = CW'(N - 1);
`ifdef MULDIV_DIV_EN
                        sa_d     = is_signed && a[N-1];
                        is_div_d = is_div;
                        if (is_div && b_zero) dbz_d = 1'b1;
`endif
                    end
                end
            end
            RUN: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    if (shifted >= {1'b0, bm_q}) begin
                        acc_d = diff[N-1:0];
                        quo_d = {quo_q[N-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[N-1:0];
                        quo_d = {quo_q[N-2:0], 1'b0};
                    end
                end else begin
                    {acc_d, quo_d} = {sum, quo_q[N-1:1]};
                end
`else
                {acc_d, quo_d} = {sum, quo_q[N-1:1]};
`endif
            end
            FIX: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = neg_q ? -quo_q : quo_q;
                    hi_d = sa_q ? -acc_q : acc_q;
                end else begin
                    if (neg_q) prod = -prod;
                    {hi_d, lo_d} = prod;
                end
`else
                if (neg_q) prod = -prod;
                {hi_d, lo_d} = prod;
`endif
            end
            default: ;
        endcase
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model plus directed vectors.
module tb_muldiv_seq;

    localparam int N = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic         op_valid;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         op_ready, busy, done, div_by_zero;
    logic [N-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    bit           m_busy = 0, m_done = 0, m_dbz = 0;
    logic [N-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;

    muldiv_seq #(.N(N)) dut (
        .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op(op),
        .a(a), .b(b), .op_ready(op_ready), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results come straight from wide integer arithmetic.
    task automatic model_accept();
        logic [63:0] ea, eb, p;
        longint      sa, sb, q, r;
        case (op)
            3'd0, 3'd1: begin
                ea = (op == 3'd0) ? {{32{a[31]}}, a} : {32'd0, a};
                eb = (op == 3'd0) ? {{32{b[31]}}, b} : {32'd0, b};
                p  = ea * eb;
                {p_hi, p_lo} = p;
                m_busy = 1; m_left = N + 1; m_dbz = 0;
            end
            3'd2, 3'd3: begin
                m_busy = 1;
                m_dbz  = DIV_EN && (b == '0);
                if (!DIV_EN || b == '0) begin
                    p_hi = m_hi; p_lo = m_lo; m_left = 1;
                end else begin
                    m_left = N + 1;
                    if (op == 3'd2) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                        q  = sa / sb;
                        r  = sa % sb;
                        p_lo = N'(q);
                        p_hi = N'(r);
                    end else begin
                        p_lo = a / b;
                        p_hi = a % b;
                    end
                end
            end
            3'd4: begin m_hi = a; m_dbz = 0; end
            3'd5: begin m_lo = a; m_dbz = 0; end
            default: ;
        endcase
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
                end
            end else if (op_valid) begin
                model_accept();
            end
        end
    end

    always @(negedge clock) begin
        check_output("m_ready", {63'd0, op_ready}, {63'd0, !m_busy});
        check_output("m_busy",  {63'd0, busy},     {63'd0, m_busy});
        check_output("m_done",  {63'd0, done},     {63'd0, m_done});
        check_output("m_dbz",   {63'd0, div_by_zero}, {63'd0, m_dbz});
        check_output("m_hi",    {32'd0, hi}, {32'd0, m_hi});
        check_output("m_lo",    {32'd0, lo}, {32'd0, m_lo});
    end

    task automatic apply_stimulus(input logic [2:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                                  input bit keep);
        op = o; a = av; b = bv; op_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (op_ready) begin
                @(posedge clock);
                #1;
                if (!keep) op_valid = 1'b0;
                return;
            end
        end
        checks++; failures++;
        $display("[TB] FAIL accept_timeout: got no accept expected accept within 100 cycles");
        op_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (done) return;
            @(posedge clock);
            lat++;
        end
        checks++; failures++;
        $display("[TB] FAIL done_timeout: got no done expected done within 100 cycles");
    endtask

    int lat, bc;

    initial begin
        reset_n = 1'b0; op_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        check_output("rst_ready", {63'd0, op_ready}, 64'd1);
        check_output("rst_busy",  {63'd0, busy}, 64'd0);
        check_output("rst_hi",    {32'd0, hi}, 64'd0);
        check_output("rst_lo",    {32'd0, lo}, 64'd0);
        reset_n = 1'b1;

        apply_stimulus(3'd0, 32'd7, 32'hFFFFFFFD, 0);
        wait_done(lat, bc);
        check_output("mult_lat", 64'(lat), 64'd33);
        check_output("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
        check_output("mult_lo", {32'd0, lo}, 64'hFFFFFFEB);

        apply_stimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        wait_done(lat, bc);
        check_output("multu_busy", 64'(bc), 64'd33);
        check_output("multu_hi", {32'd0, hi}, 64'hFFFFFFFE);
        check_output("multu_lo", {32'd0, lo}, 64'h00000001);

`ifdef MULDIV_DIV_EN
        apply_stimulus(3'd2, 32'hFFFFFFF9, 32'd2, 0);
        wait_done(lat, bc);
        check_output("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
        check_output("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
        apply_stimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        wait_done(lat, bc);
        check_output("divovf_lo", {32'd0, lo}, 64'h80000000);
        check_output("divovf_hi", {32'd0, hi}, 64'd0);
        apply_stimulus(3'd3, 32'd100, 32'd7, 0);
        wait_done(lat, bc);
        check_output("divu_lo", {32'd0, lo}, 64'd14);
        check_output("divu_hi", {32'd0, hi}, 64'd2);
`endif

        apply_stimulus(3'd5, 32'h1234, 32'd0, 0);
        @(negedge clock);
        check_output("mtlo_lo", {32'd0, lo}, 64'h1234);
        check_output("mtlo_busy", {63'd0, busy}, 64'd0);
        apply_stimulus(3'd3, 32'd5, 32'd0, 0);
        wait_done(lat, bc);
        check_output("dz_lat", 64'(lat), 64'd1);
        check_output("dz_lo", {32'd0, lo}, 64'h1234);
        check_output("dz_flag", {63'd0, div_by_zero}, {63'd0, DIV_EN});
        apply_stimulus(3'd4, 32'hABCD, 32'd0, 0);
        @(negedge clock);
        check_output("mthi_hi", {32'd0, hi}, 64'hABCD);
        check_output("mthi_dbz", {63'd0, div_by_zero}, 64'd0);

        op = 3'd6; a = 32'h5A5A; op_valid = 1'b1;
        repeat (4) @(negedge clock);
        check_output("undef_ready", {63'd0, op_ready}, 64'd1);
        check_output("undef_hi", {32'd0, hi}, 64'hABCD);
        op_valid = 1'b0;

        apply_stimulus(3'd0, 32'd3, 32'd4, 1);
        op = 3'd5; a = 32'h55;
        wait_done(lat, bc);
        check_output("b2b_lat", 64'(lat), 64'd33);
        check_output("b2b_lo_done", {32'd0, lo}, 64'd12);
        @(negedge clock);
        check_output("b2b_lo_next", {32'd0, lo}, 64'h55);
        op_valid = 1'b0;

        apply_stimulus(3'd0, 32'd100, 32'd200, 0);
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_output("arst_busy",  {63'd0, busy}, 64'd0);
        check_output("arst_ready", {63'd0, op_ready}, 64'd1);
        check_output("arst_hi",    {32'd0, hi}, 64'd0);
        check_output("arst_lo",    {32'd0, lo}, 64'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;

        apply_stimulus(3'd0, 32'hFFFFFFFF, 32'd5, 0);
        wait_done(lat, bc);
        check_output("post_lat", 64'(lat), 64'd33);
        check_output("post_hi", {32'd0, hi}, 64'hFFFFFFFF);
        check_output("post_lo", {32'd0, lo}, 64'hFFFFFFFB);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
